// File: rtl/load_store_queue.sv
// In-order load/store queue feeding a single data-memory port, with load write-back formatting.
// Optional misaligned-access trapping is enabled by defining LSQ_MISALIGN_CHECK_EN.
module load_store_queue #(
    parameter int C_XLEN  = 32,
    parameter int C_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    output logic              ex_lq_full_o,
    input  logic              ex_lq_wr_i,
    input  logic              ex_sq_wr_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [4:0]        ex_regd_addr_i,
    input  logic [C_XLEN-1:0] ex_regs2_data_i,
    input  logic [C_XLEN-1:0] ex_addr_i,
    output logic              dmem_req_o,
    output logic              dmem_wr_o,
    output logic [C_XLEN-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [C_XLEN-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [C_XLEN-1:0] dmem_rdata_i,
    output logic              regd_wr_o,
    output logic [4:0]        regd_addr_o,
    output logic [C_XLEN-1:0] regd_data_o,
    output logic              hvec_lma_o,
    output logic              hvec_sma_o
);
    localparam int PW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int CW = $clog2(C_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(C_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state_q, state_d;

    logic              q_store  [C_DEPTH];
    logic [2:0]        q_funct3 [C_DEPTH];
    logic [4:0]        q_regd   [C_DEPTH];
    logic [C_XLEN-1:0] q_data   [C_DEPTH];
    logic [C_XLEN-1:0] q_addr   [C_DEPTH];

    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    logic              req_q, req_d;
    logic              req_wr_q, req_wr_d;
    logic [C_XLEN-1:0] req_addr_q, req_addr_d;
    logic [3:0]        req_be_q, req_be_d;
    logic [C_XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [2:0]        req_funct3_q, req_funct3_d;
    logic [1:0]        req_off_q, req_off_d;
    logic [4:0]        req_regd_q, req_regd_d;

    logic              regd_wr_q, regd_wr_d;
    logic [4:0]        regd_addr_q, regd_addr_d;
    logic [C_XLEN-1:0] regd_data_q, regd_data_d;
    logic              lma_q, lma_d, sma_q, sma_d;

    logic              head_store;
    logic [2:0]        head_funct3;
    logic [C_XLEN-1:0] head_addr;
    logic [C_XLEN-1:0] head_data;
    logic [3:0]        head_be;
    logic [C_XLEN-1:0] head_wdata;
    logic [C_XLEN-1:0] load_fmt;

    assign ex_lq_full_o = (count_q == FULL_CNT);
    assign push = (ex_lq_wr_i | ex_sq_wr_i) & ~ex_lq_full_o;
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign head_store  = q_store[rptr_q];
    assign head_funct3 = q_funct3[rptr_q];
    assign head_addr   = q_addr[rptr_q];
    assign head_data   = q_data[rptr_q];

    // Byte-lane mask and lane-replicated data; the 4-bit shift truncates masks past lane 3.
    always_comb begin
        head_be    = 4'b1111;
        head_wdata = head_data;
        case (head_funct3[1:0])
            2'b00: begin
                head_be    = 4'b0001 << head_addr[1:0];
                head_wdata = {4{head_data[7:0]}};
            end
            2'b01: begin
                head_be    = 4'b0011 << head_addr[1:0];
                head_wdata = {2{head_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_fmt = dmem_rdata_i;
        case (req_funct3_q[1:0])
            2'b00: begin
                load_fmt[7:0]  = dmem_rdata_i[{req_off_q, 3'b000} +: 8];
                load_fmt[31:8] = {24{~req_funct3_q[2] & load_fmt[7]}};
            end
            2'b01: begin
                load_fmt[15:0]  = dmem_rdata_i[{req_off_q[1], 4'b0000} +: 16];
                load_fmt[31:16] = {16{~req_funct3_q[2] & load_fmt[15]}};
            end
            default: ;
        endcase
    end

`ifdef LSQ_MISALIGN_CHECK_EN
    logic head_misalign;
    assign head_misalign = ((head_funct3[1:0] == 2'b01) && head_addr[0]) ||
                           ((head_funct3[1:0] == 2'b10) && (head_addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        req_d        = req_q;
        req_wr_d     = req_wr_q;
        req_addr_d   = req_addr_q;
        req_be_d     = req_be_q;
        req_wdata_d  = req_wdata_q;
        req_funct3_d = req_funct3_q;
        req_off_d    = req_off_q;
        req_regd_d   = req_regd_q;
        regd_wr_d    = 1'b0;
        regd_addr_d  = regd_addr_q;
        regd_data_d  = regd_data_q;
        lma_d        = 1'b0;
        sma_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
`ifdef LSQ_MISALIGN_CHECK_EN
                    if (head_misalign) begin
                        pop   = 1'b1;
                        lma_d = ~head_store;
                        sma_d = head_store;
                    end else
`endif
                    begin
                        req_d        = 1'b1;
                        req_wr_d     = head_store;
                        req_addr_d   = {head_addr[C_XLEN-1:2], 2'b00};
                        req_be_d     = head_be;
                        req_wdata_d  = head_wdata;
                        req_funct3_d = head_funct3;
                        req_off_d    = head_addr[1:0];
                        req_regd_d   = q_regd[rptr_q];
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ack_i) begin
                    pop     = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!req_wr_q) begin
                        regd_wr_d   = 1'b1;
                        regd_addr_d = req_regd_q;
                        regd_data_d = load_fmt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            req_q        <= 1'b0;
            req_wr_q     <= 1'b0;
            req_addr_q   <= '0;
            req_be_q     <= '0;
            req_wdata_q  <= '0;
            req_funct3_q <= '0;
            req_off_q    <= '0;
            req_regd_q   <= '0;
            regd_wr_q    <= 1'b0;
            regd_addr_q  <= '0;
            regd_data_q  <= '0;
            lma_q        <= 1'b0;
            sma_q        <= 1'b0;
        end else if (clk_en_i) begin
            state_q      <= state_d;
            count_q      <= count_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            req_q        <= req_d;
            req_wr_q     <= req_wr_d;
            req_addr_q   <= req_addr_d;
            req_be_q     <= req_be_d;
            req_wdata_q  <= req_wdata_d;
            req_funct3_q <= req_funct3_d;
            req_off_q    <= req_off_d;
            req_regd_q   <= req_regd_d;
            regd_wr_q    <= regd_wr_d;
            regd_addr_q  <= regd_addr_d;
            regd_data_q  <= regd_data_d;
            lma_q        <= lma_d;
            sma_q        <= sma_d;
        end
    end

    // Entry storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk_i) begin
        if (clk_en_i && push) begin
            q_store[wptr_q]  <= ex_sq_wr_i;
            q_funct3[wptr_q] <= ex_funct3_i;
            q_regd[wptr_q]   <= ex_regd_addr_i;
            q_data[wptr_q]   <= ex_regs2_data_i;
            q_addr[wptr_q]   <= ex_addr_i;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_wr_o    = req_wr_q;
    assign dmem_addr_o  = req_addr_q;
    assign dmem_be_o    = req_be_q;
    assign dmem_wdata_o = req_wdata_q;
    assign regd_wr_o    = regd_wr_q;
    assign regd_addr_o  = regd_addr_q;
    assign regd_data_o  = regd_data_q;

`ifdef LSQ_MISALIGN_CHECK_EN
    assign hvec_lma_o = lma_q;
    assign hvec_sma_o = sma_q;
`else
    assign hvec_lma_o = 1'b0;
    assign hvec_sma_o = 1'b0;
    logic unused_exc;
    assign unused_exc = lma_q | sma_q;
`endif

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue with request/write-back scoreboards.
// Misalignment steps run only when LSQ_MISALIGN_CHECK_EN is defined.
module tb_load_store_queue;
    logic        clk_i = 1'b0;
    logic        resetb_i;
    logic        clk_en_i;
    logic        ex_lq_full_o;
    logic        ex_lq_wr_i;
    logic        ex_sq_wr_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  ex_regd_addr_i;
    logic [31:0] ex_regs2_data_i;
    logic [31:0] ex_addr_i;
    logic        dmem_req_o;
    logic        dmem_wr_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        regd_wr_o;
    logic [4:0]  regd_addr_o;
    logic [31:0] regd_data_o;
    logic        hvec_lma_o;
    logic        hvec_sma_o;

    // Request entry: {wr, addr[31:0], be[3:0], wdata[31:0]}; write-back entry: {rdata, regd, data}.
    logic [68:0] req_exp_q[$];
    logic [68:0] wb_exp_q[$];

    int total = 0;
    int bad = 0;
    int last_req_cycles = 0;
    logic full_after_ack = 1'b0;

    load_store_queue #(.C_XLEN(32), .C_DEPTH(4)) dut (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .ex_lq_full_o(ex_lq_full_o), .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i),
        .ex_funct3_i(ex_funct3_i), .ex_regd_addr_i(ex_regd_addr_i),
        .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
        .dmem_req_o(dmem_req_o), .dmem_wr_o(dmem_wr_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .regd_wr_o(regd_wr_o), .regd_addr_o(regd_addr_o),
        .regd_data_o(regd_data_o), .hvec_lma_o(hvec_lma_o), .hvec_sma_o(hvec_sma_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] b;
        int o;
        b = 4'b0000;
        o = int'(a[1:0]);
        if (f3[1:0] == 2'b00) b[o] = 1'b1;
        else if (f3[1:0] == 2'b01) begin
            b[o] = 1'b1;
            if (o < 3) b[o+1] = 1'b1;
        end else b = 4'b1111;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        for (int i = 0; i < 4; i++) begin
            if (f3[1:0] == 2'b00) w[8*i +: 8] = d[7:0];
            else if (f3[1:0] == 2'b01) w[8*i +: 8] = d[8*(i%2) +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] s;
        logic [31:0] r;
        s = rd >> (8 * int'(a[1:0]));
        r = rd;
        if (f3[1:0] == 2'b00) r = f3[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        else if (f3[1:0] == 2'b01) r = f3[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return r;
    endfunction

    task automatic enq(input logic st, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] d,
                       input logic [31:0] a, input logic [31:0] rdata, input logic accept, input logic issues);
        ex_lq_wr_i      = ~st;
        ex_sq_wr_i      = st;
        ex_funct3_i     = f3;
        ex_regd_addr_i  = rd;
        ex_regs2_data_i = d;
        ex_addr_i       = a;
        step();
        ex_lq_wr_i = 1'b0;
        ex_sq_wr_i = 1'b0;
        if (accept && issues) begin
            req_exp_q.push_back({st, a & 32'hFFFF_FFFC, m_be(f3, a), m_wdata(f3, d)});
            if (!st) wb_exp_q.push_back({rdata, rd, m_load(f3, a, rdata)});
        end
    endtask

    task automatic serve(input int dly);
        int n;
        logic [68:0] e;
        logic [68:0] w;
        n = 0;
        while (dmem_req_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("req_seen", dmem_req_o, 1);
        if (dmem_req_o !== 1'b1) return;
        check("req_expected", req_exp_q.size() != 0, 1);
        if (req_exp_q.size() == 0) return;
        e = req_exp_q.pop_front();
        check("dmem_wr", dmem_wr_o, e[68]);
        check("dmem_addr", dmem_addr_o, e[67:36]);
        check("dmem_be", dmem_be_o, e[35:32]);
        if (e[68]) check("dmem_wdata", dmem_wdata_o, e[31:0]);
        last_req_cycles = 1;
        for (int i = 0; i < dly; i++) begin
            step();
            check("req_hold", dmem_req_o, 1);
            check("addr_hold", dmem_addr_o, e[67:36]);
            last_req_cycles++;
        end
        w = '0;
        if (!e[68]) begin
            check("wb_expected", wb_exp_q.size() != 0, 1);
            if (wb_exp_q.size() != 0) w = wb_exp_q.pop_front();
            dmem_rdata_i = w[68:37];
        end else begin
            dmem_rdata_i = $urandom;
        end
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        full_after_ack = ex_lq_full_o;
        check("req_drop", dmem_req_o, 0);
        check("hvec_lma_idle", hvec_lma_o, 0);
        check("hvec_sma_idle", hvec_sma_o, 0);
        if (!e[68]) begin
            check("regd_wr", regd_wr_o, 1);
            check("regd_addr", regd_addr_o, w[36:32]);
            check("regd_data", regd_data_o, w[31:0]);
        end else begin
            check("store_no_wb", regd_wr_o, 0);
        end
        step();
        check("regd_wr_pulse", regd_wr_o, 0);
    endtask

    initial begin
        resetb_i = 1'b0;
        clk_en_i = 1'b1;
        ex_lq_wr_i = 1'b0;
        ex_sq_wr_i = 1'b0;
        ex_funct3_i = 3'b000;
        ex_regd_addr_i = 5'd0;
        ex_regs2_data_i = 32'h0;
        ex_addr_i = 32'h0;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        step();
        step();
        check("rst_full", ex_lq_full_o, 0);
        check("rst_req", dmem_req_o, 0);
        check("rst_wr", dmem_wr_o, 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_wdata", dmem_wdata_o, 0);
        check("rst_regd_wr", regd_wr_o, 0);
        check("rst_regd_addr", regd_addr_o, 0);
        check("rst_regd_data", regd_data_o, 0);
        check("rst_lma", hvec_lma_o, 0);
        check("rst_sma", hvec_sma_o, 0);
        resetb_i = 1'b1;
        step();

        // SW 0x100, ack two cycles into the request: request is high for three cycles.
        enq(1'b1, 3'b010, 5'd0, 32'hDEADBEEF, 32'h100, 32'h0, 1'b1, 1'b1);
        step();
        check("sw_latency_req", dmem_req_o, 1);
        serve(2);
        check("sw_req_cycles", last_req_cycles, 3);

        // LB / LBU of the top byte lane.
        enq(1'b0, 3'b000, 5'd5, 32'h0, 32'h203, 32'h80FFFFFF, 1'b1, 1'b1);
        serve(0);
        enq(1'b0, 3'b100, 5'd5, 32'h0, 32'h203, 32'h80FFFFFF, 1'b1, 1'b1);
        serve(1);

        // SH into the upper halfword, then LH/LHU of both halves.
        enq(1'b1, 3'b001, 5'd0, 32'h0000A5C3, 32'h12, 32'h0, 1'b1, 1'b1);
        serve(0);
        enq(1'b0, 3'b001, 5'd9, 32'h0, 32'h22, 32'h9ABC1234, 1'b1, 1'b1);
        serve(0);
        enq(1'b0, 3'b101, 5'd10, 32'h0, 32'h20, 32'h1234F00D, 1'b1, 1'b1);
        serve(0);
        enq(1'b1, 3'b000, 5'd0, 32'h000000C7, 32'h31, 32'h0, 1'b1, 1'b1);
        serve(0);

        // Clock enable low freezes a pending request even with ack asserted.
        enq(1'b1, 3'b010, 5'd0, 32'h12345678, 32'h40, 32'h0, 1'b1, 1'b1);
        step();
        clk_en_i = 1'b0;
        dmem_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("clken_req_hold", dmem_req_o, 1);
        end
        dmem_ack_i = 1'b0;
        clk_en_i = 1'b1;
        serve(1);

        // Fill the queue with ack withheld; the fifth enqueue is dropped.
        enq(1'b0, 3'b010, 5'd1, 32'h0, 32'h400, $urandom, 1'b1, 1'b1);
        enq(1'b0, 3'b001, 5'd2, 32'h0, 32'h406, $urandom, 1'b1, 1'b1);
        enq(1'b0, 3'b000, 5'd3, 32'h0, 32'h409, $urandom, 1'b1, 1'b1);
        check("full_at_3", ex_lq_full_o, 0);
        enq(1'b0, 3'b100, 5'd4, 32'h0, 32'h40E, $urandom, 1'b1, 1'b1);
        check("full_at_4", ex_lq_full_o, 1);
        enq(1'b0, 3'b010, 5'd31, 32'h0, 32'h500, $urandom, 1'b0, 1'b0);
        check("full_after_5th", ex_lq_full_o, 1);
        serve(0);
        check("full_falls", full_after_ack, 0);
        for (int i = 0; i < 3; i++) serve($urandom_range(0, 2));

`ifdef LSQ_MISALIGN_CHECK_EN
        enq(1'b0, 3'b010, 5'd7, 32'h0, 32'h302, 32'h0, 1'b1, 1'b0);
        step();
        check("lma_pulse", hvec_lma_o, 1);
        check("lma_no_sma", hvec_sma_o, 0);
        check("lma_no_req", dmem_req_o, 0);
        step();
        check("lma_end", hvec_lma_o, 0);
        check("lma_no_req2", dmem_req_o, 0);
        check("lma_no_wb", regd_wr_o, 0);
        enq(1'b1, 3'b001, 5'd0, 32'h1111, 32'h101, 32'h0, 1'b1, 1'b0);
        step();
        check("sma_pulse", hvec_sma_o, 1);
        check("sma_no_req", dmem_req_o, 0);
        step();
        check("sma_end", hvec_sma_o, 0);
        enq(1'b1, 3'b010, 5'd0, 32'hCAFEF00D, 32'h304, 32'h0, 1'b1, 1'b1);
        serve(0);
`endif

        // Reset during a pending request with three entries queued.
        enq(1'b0, 3'b010, 5'd11, 32'h0, 32'h600, 32'h11111111, 1'b1, 1'b1);
        enq(1'b0, 3'b010, 5'd12, 32'h0, 32'h604, 32'h22222222, 1'b1, 1'b1);
        enq(1'b0, 3'b010, 5'd13, 32'h0, 32'h608, 32'h33333333, 1'b1, 1'b1);
        check("pre_reset_req", dmem_req_o, 1);
        resetb_i = 1'b0;
        #1;
        check("async_rst_req", dmem_req_o, 0);
        check("async_rst_wb", regd_wr_o, 0);
        check("async_rst_full", ex_lq_full_o, 0);
        req_exp_q.delete();
        wb_exp_q.delete();
        step();
        resetb_i = 1'b1;
        dmem_ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_req", dmem_req_o, 0);
            check("post_rst_wb", regd_wr_o, 0);
        end
        dmem_ack_i = 1'b0;

        // Queue still usable after reset.
        enq(1'b0, 3'b000, 5'd20, 32'h0, 32'h701, 32'h0000_7F00, 1'b1, 1'b1);
        serve(0);
        step();
        check("end_idle_req", dmem_req_o, 0);
        check("end_req_q_empty", req_exp_q.size(), 0);
        check("end_wb_q_empty", wb_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_queue.md
# load_store_queue

In-order load/store queue between the execute stage and the data-memory port. It accepts committed load and store entries from the execute stage and back-pressures it with a full flag. Entries are issued to data memory one at a time, and load results are formatted and written back to the register file. It is the responder end of the execute stage's load/store-queue write interface.

## Interface

**Parameters**
- C_XLEN, 32, data/address width; only 32 is supported.
- C_DEPTH, 4, number of queue entries; must be a power of two, 2..16.

**Ports**
- clk_i  in  1  clock.
- resetb_i  in  1  asynchronous active-low reset.
- clk_en_i  in  1  global clock enable; no state changes while low.
- ex_lq_full_o  out  1  queue full; the execute stage must stall.
- ex_lq_wr_i  in  1  enqueue a load.
- ex_sq_wr_i  in  1  enqueue a store; never asserted together with ex_lq_wr_i.
- ex_funct3_i  in  3  access size and sign (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW encodings).
- ex_regd_addr_i  in  5  load destination register.
- ex_regs2_data_i  in  C_XLEN  store data.
- ex_addr_i  in  C_XLEN  byte address.
- dmem_req_o  out  1  memory request valid.
- dmem_wr_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  C_XLEN  word-aligned address; bits [1:0] are 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  C_XLEN  store data, lane-replicated.
- dmem_ack_i  in  1  request accepted and complete; dmem_rdata_i is valid in the same cycle.
- dmem_rdata_i  in  C_XLEN  load read word.
- regd_wr_o  out  1  load write-back strobe.
- regd_addr_o  out  5  write-back register.
- regd_data_o  out  C_XLEN  write-back data.
- hvec_lma_o  out  1  misaligned-load exception pulse. Present only when the configuration macro is defined; tied to 0 otherwise.
- hvec_sma_o  out  1  misaligned-store exception pulse. Same configuration rule as hvec_lma_o.

**Reset values**
- All outputs are 0.
- Queue is empty and state is IDLE.

## Operation

**Queue**
- Circular buffer with read/write pointers and a count register of width clog2(C_DEPTH)+1.
- Each entry holds: type (load/store), funct3, regd_addr, data and addr.
- ex_lq_full_o = (count == C_DEPTH). It is a combinational decode of the count register, so it does not see a pop in the same cycle.
- An enqueue arriving while full is ignored. The execute stage guarantees this never happens.
- Pointers wrap modulo C_DEPTH.
- A simultaneous enqueue and pop leaves count unchanged.

**State machine**
- IDLE: if count != 0, latch the head entry into the request registers, assert dmem_req_o and move to REQ.
- REQ: hold dmem_req_o and all dmem_* outputs stable until dmem_ack_i.
  - On dmem_ack_i: pop the head and deassert dmem_req_o.
  - For a load, also register the formatted data, pulse regd_wr_o for 1 cycle, and drive regd_addr_o.
  - Return to IDLE.
- A store never produces a write-back.

**Store formatting**
- SB: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
- SH: be = 0011 << addr[1:0]; wdata = halfword replicated ×2.
- SW: be = 1111; wdata = data.

**Load formatting**
- Select the byte or halfword lane of dmem_rdata_i using addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- dmem_be_o for loads follows the same mask rule as stores.

## Timing

- An enqueue sampled at edge E0 is counted from E0. If the state is IDLE, dmem_req_o rises after edge E1. Minimum enqueue-to-request latency is 1 cycle.
- With dmem_ack_i sampled at edge Ek:
  - The pop happens at Ek.
  - regd_wr_o is high in cycle Ek..Ek+1.
  - dmem_req_o is low for at least 1 cycle.
- Peak throughput is one access per 2 cycles.
- ex_lq_full_o falls the cycle after a pop from a full queue.
- When clk_en_i is low, all registers hold, including a pending request.
- Reset asserted mid-request immediately drops dmem_req_o, regd_wr_o and the exception outputs, and empties the queue.

## Configuration

**LSQ_MISALIGN_CHECK_EN**
- Defined:
  - A head entry is misaligned when it is a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
  - In IDLE, a misaligned head is not issued. It is popped and, in the same registered cycle as the pop, hvec_lma_o (load) or hvec_sma_o (store) pulses for 1 cycle.
  - No write-back occurs for a misaligned entry.
- Undefined:
  - No check is made. The access is issued with the address low bits ignored, and masks are truncated to 4 bits.
  - hvec_lma_o and hvec_sma_o are tied to 0.

## Test plan

- Reset, then an SW of addr 0x100, data 0xDEADBEEF, with dmem_ack_i 2 cycles after request → dmem_addr_o=0x100, be=1111, wdata=0xDEADBEEF, req held 3 cycles, no regd_wr_o.
- LB of addr 0x203, regd_addr 5, rdata 0x80FFFFFF → regd_wr_o pulse, regd_addr_o=5, regd_data_o=0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH of addr 0x12, data 0x0000A5C3 → be=1100, wdata=0xA5C3A5C3, addr=0x10.
- Enqueue 4 loads back-to-back with ack withheld → ex_lq_full_o=1 after the 4th. A 5th enqueue is ignored. After ack, full falls the next cycle, and the 4 write-backs occur in order with correct registers.
- With LSQ_MISALIGN_CHECK_EN defined, LW of addr 0x302 → no dmem_req_o, hvec_lma_o pulses once, queue empties. A following SW of addr 0x304 then issues normally.
- Reset pulsed while REQ is pending with 3 entries queued → dmem_req_o=0 immediately, count=0, and no write-back after reset is released.
